// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the unified-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 3;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable 4-bit down-counter that times the memory read latency window.
// Latency: load/decrement visible the cycle after the strobe; last is combinational on the count.
// Backpressure: none; decrements stop at zero.
//
// Ports: clk, rst_n; load/load_val reload the count; dec decrements;
//        last is high while the count equals 1.
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data access.
// Latency: request seen in cycle t acks in cycle t+MEM_LAT+2; next grant no earlier than t+MEM_LAT+3.
// Backpressure: a requester is stalled while its req is high and its ack is low; loser stays pending.
//
// Ports: clk, rst_n (async active-low); if_req/if_addr -> if_rdata/if_ack;
//        d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack; registered mem_en/mem_we/mem_addr/mem_wdata
//        to the memory, mem_rdata back from it.
// Optional: define MEM_PORT_ARBITER_STATS_EN to add stat_xfers and stat_conflicts counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 9,
    parameter int DW         = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    output logic [15:0]   stat_xfers,
    output logic [15:0]   stat_conflicts
`endif
);

    localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_MAX);

    state_t           state, state_d;
    gnt_t             gnt, win;
    logic             txn_we;
    logic [CNT_W-1:0] starve_cnt;

    logic both_req, any_req;
    logic take, cap, cnt_load, cnt_dec, cnt_last;
    logic mem_en_d, mem_we_d, if_ack_d, d_ack_d;

    assign both_req = if_req && d_req;
    assign any_req  = if_req || d_req;

    // Data has priority except when fetch has lost STARVE_MAX conflicts in a row.
    assign win = (d_req && !(both_req && (starve_cnt == STARVE_C))) ? GNT_D : GNT_IF;

    mem_arb_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LAT_C),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    // Next state plus next values of the registered outputs. mem_en/mem_we are
    // computed on the IDLE->ISSUE edge so they are high exactly in the ISSUE
    // cycle; acks are computed on WAIT->RESP so they pulse in the RESP cycle.
    always_comb begin
        state_d  = state;
        take     = 1'b0;
        cap      = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if_ack_d = 1'b0;
        d_ack_d  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    take     = 1'b1;
                    mem_en_d = 1'b1;
                    mem_we_d = (win == GNT_D) && d_we;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    cap      = 1'b1;
                    if_ack_d = (gnt == GNT_IF);
                    d_ack_d  = (gnt == GNT_D);
                    state_d  = RESP;
                end
            end
            RESP: begin
                // Requests are deliberately not sampled here.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= GNT_IF;
            txn_we     <= 1'b0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state  <= state_d;
            mem_en <= mem_en_d;
            mem_we <= mem_we_d;
            if_ack <= if_ack_d;
            d_ack  <= d_ack_d;
            if (take) begin
                gnt       <= win;
                txn_we    <= (win == GNT_D) && d_we;
                mem_addr  <= (win == GNT_D) ? d_addr : if_addr;
                mem_wdata <= (win == GNT_D) ? d_wdata : '0;
                if (win == GNT_IF) begin
                    starve_cnt <= '0;
                end else if (both_req && (starve_cnt != '1)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            // Stores leave both read-data registers untouched.
            if (cap && !txn_we) begin
                if (gnt == GNT_IF) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

`ifdef MEM_PORT_ARBITER_STATS_EN
    // Free-running 16-bit counters; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_xfers     <= '0;
            stat_conflicts <= '0;
        end else begin
            if (state == RESP) begin
                stat_xfers <= stat_xfers + 16'd1;
            end
            if ((state == IDLE) && both_req) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic vs a reference model.
// Latency: checks acks at grant+MEM_LAT+2 and memory strobes at grant+1.
// Backpressure: requesters hold req until their ack, then drop it in the ack cycle.
module tb_mem_port_arbiter;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int SMAX  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Instance A (MEM_LAT=2)
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [8:0]  if_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_en, mem_we;
    logic [8:0]  mem_addr;

    // Instance B (MEM_LAT=1)
    logic        b_if_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [8:0]  b_if_addr = '0, b_d_addr = '0;
    logic [31:0] b_d_wdata = '0;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we;
    logic [8:0]  b_mem_addr;

`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [15:0] stat_xfers, stat_conflicts, b_stat_xfers, b_stat_conflicts;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(9), .DW(32), .MEM_LAT(LAT_A), .STARVE_MAX(SMAX)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARBITER_STATS_EN
        , .stat_xfers(stat_xfers), .stat_conflicts(stat_conflicts)
`endif
    );

    mem_port_arbiter #(.AW(9), .DW(32), .MEM_LAT(LAT_B), .STARVE_MAX(SMAX)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
`ifdef MEM_PORT_ARBITER_STATS_EN
        , .stat_xfers(b_stat_xfers), .stat_conflicts(b_stat_conflicts)
`endif
    );

    // Memory models: contents initialised on the first clock (inside reset).
    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];
    logic [31:0] a_p1, a_p2, b_p1;
    bit          init_done;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 512; i++) begin
                mem_a[i] <= 32'h5A00_0000 | 32'(i);
                mem_b[i] <= 32'h3C00_0000 | 32'(i);
            end
            mem_a[5] <= 32'hDEAD_BEEF;
            mem_b[3] <= 32'hCAFE_F00D;
            init_done <= 1'b1;
        end else begin
            if (mem_en) begin
                if (mem_we) mem_a[mem_addr] <= mem_wdata;
                a_p1 <= mem_a[mem_addr];
            end
            if (b_mem_en) begin
                if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
                b_p1 <= mem_b[b_mem_addr];
            end
        end
        a_p2 <= a_p1;
    end
    assign mem_rdata   = a_p2;
    assign b_mem_rdata = b_p1;

    // Bookkeeping and reference model state for instance A.
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] ref_mem [0:511];
    bit          act;
    int          g_cyc, free_at, starve;
    bit          t_d, t_we;
    logic [8:0]  t_addr;
    logic [31:0] t_wdata, t_data;
    logic [31:0] e_if_rdata, e_d_rdata;
    int          n_xfer_exp, n_conf_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        act = 1'b0; starve = 0;
        e_if_rdata = '0; e_d_rdata = '0;
        n_xfer_exp = 0; n_conf_exp = 0;
    endtask

    // Grant decision for the current cycle from the arbitration rules.
    task automatic model_cycle();
        if (!(act && cyc < free_at) && (if_req || d_req)) begin
            if (if_req && d_req) n_conf_exp++;
            t_d = d_req && !(if_req && starve == SMAX);
            if (!t_d) starve = 0;
            else if (if_req && starve < 15) starve++;
            t_addr  = t_d ? d_addr : if_addr;
            t_we    = t_d && d_we;
            t_wdata = d_wdata;
            if (t_we) ref_mem[t_addr] = t_wdata;
            t_data  = ref_mem[t_addr];
            act     = 1'b1;
            g_cyc   = cyc;
            free_at = cyc + LAT_A + 3;
        end
    endtask

    task automatic check_outputs();
        bit e_en, e_ack;
        e_en  = act && (cyc == g_cyc + 1);
        e_ack = act && (cyc == g_cyc + LAT_A + 2);
        if (e_ack) begin
            n_xfer_exp++;
            if (!t_we) begin
                if (t_d) e_d_rdata = t_data;
                else     e_if_rdata = t_data;
            end
        end
        chk("if_ack", 32'(if_ack), 32'(e_ack && !t_d));
        chk("d_ack", 32'(d_ack), 32'(e_ack && t_d));
        chk("ack_excl", 32'(if_ack && d_ack), 32'(0));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_en && t_we));
        if (e_en) chk("mem_addr", 32'(mem_addr), 32'(t_addr));
        if (e_en && t_we) chk("mem_wdata", mem_wdata, t_wdata);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    initial begin
        int t0;
        int n_acks;
        int got_order [0:8];
        int exp_order [0:7];

        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h5A00_0000 | 32'(i);
        ref_mem[5] = 32'hDEAD_BEEF;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_ack", 32'(if_ack), 32'(0));
        chk("rst_d_ack", 32'(d_ack), 32'(0));
        chk("rst_mem_en", 32'(mem_en), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", mem_wdata, 32'(0));
        chk("rst_if_rdata", if_rdata, 32'(0));
        chk("rst_d_rdata", d_rdata, 32'(0));
        chk("rst_b_mem_en", 32'(b_mem_en), 32'(0));
`ifdef MEM_PORT_ARBITER_STATS_EN
        chk("rst_stat_xfers", 32'(stat_xfers), 32'(0));
        chk("rst_stat_conflicts", 32'(stat_conflicts), 32'(0));
`endif
        rst_n = 1'b1;

        // Lone fetch
        if_req = 1'b1; if_addr = 9'h005; t0 = cyc;
        step();
        chk("fetch_mem_en", 32'(mem_en), 32'(1));
        chk("fetch_mem_addr", 32'(mem_addr), 32'h005);
        step(); step();
        chk("fetch_no_early_ack", 32'(if_ack), 32'(0));
        step();
        chk("fetch_ack_cycle", 32'(cyc - t0), 32'(4));
        chk("fetch_ack", 32'(if_ack), 32'(1));
        chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("fetch_no_d_ack", 32'(d_ack), 32'(0));
        if_req = 1'b0;
        step();

        // Store then load
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h010; d_wdata = 32'h1234_5678;
        step();
        chk("store_mem_we", 32'(mem_we), 32'(1));
        step(); step(); step();
        chk("store_ack", 32'(d_ack), 32'(1));
        chk("store_d_rdata_kept", d_rdata, 32'(0));
        d_req = 1'b0;
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010; d_wdata = 32'h0;
        repeat (4) step();
        chk("load_ack", 32'(d_ack), 32'(1));
        chk("load_rdata", d_rdata, 32'h1234_5678);
        chk("load_if_rdata_kept", if_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        step();

        // Simultaneous requests held continuously
        exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};
        if_req = 1'b1; if_addr = 9'h007;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020;
        n_acks = 0;
        for (int i = 0; i < 100 && n_acks < 9; i++) begin
            step();
            if (if_ack) begin
                got_order[n_acks] = 0;
                n_acks++;
                if (n_acks >= 8) if_req = 1'b0;
            end
            if (d_ack) begin
                got_order[n_acks] = 1;
                n_acks++;
                if (n_acks >= 9) d_req = 1'b0;
            end
        end
        chk("sim_acks", 32'(n_acks), 32'(9));
        for (int i = 0; i < 8; i++) chk($sformatf("grant_order[%0d]", i), 32'(got_order[i]), 32'(exp_order[i]));
        if_req = 1'b0; d_req = 1'b0;
        step();

        // Async reset in the middle of WAIT
        if_req = 1'b1; if_addr = 9'h005;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("arst_mem_en", 32'(mem_en), 32'(0));
        chk("arst_mem_addr", 32'(mem_addr), 32'(0));
        chk("arst_if_rdata", if_rdata, 32'(0));
        chk("arst_d_rdata", d_rdata, 32'(0));
        chk("arst_if_ack", 32'(if_ack), 32'(0));
        model_reset();
        #4;
        rst_n = 1'b1;
        t0 = cyc;
        repeat (4) step();
        chk("post_rst_ack_cycle", 32'(cyc - t0), 32'(4));
        chk("post_rst_ack", 32'(if_ack), 32'(1));
        chk("post_rst_rdata", if_rdata, 32'hDEAD_BEEF);
        if_req = 1'b0;
        step();

        // MEM_LAT=1 instance: lone load
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 9'h003;
        step();
        chk("b_mem_en", 32'(b_mem_en), 32'(1));
        chk("b_mem_addr", 32'(b_mem_addr), 32'h003);
        step();
        chk("b_no_ack_t2", 32'(b_d_ack), 32'(0));
        step();
        chk("b_ack_t3", 32'(b_d_ack), 32'(1));
        chk("b_rdata", b_d_rdata, 32'hCAFE_F00D);
        chk("b_if_ack", 32'(b_if_ack), 32'(0));
        b_d_req = 1'b0;
        step();
        chk("b_ack_pulse", 32'(b_d_ack), 32'(0));

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            step();
            if (if_ack) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 9'($urandom_range(0, 15));
            end
            if (d_ack) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 9'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
        end
        for (int i = 0; i < 60 && (if_req || d_req); i++) begin
            step();
            if (if_ack) if_req = 1'b0;
            if (d_ack) d_req = 1'b0;
        end
        chk("drain", 32'({if_req, d_req}), 32'(0));
        step(); step();

`ifdef MEM_PORT_ARBITER_STATS_EN
        chk("stat_xfers", 32'(stat_xfers), 32'(16'(n_xfer_exp)));
        chk("stat_conflicts", 32'(stat_conflicts), 32'(16'(n_conf_exp)));
        chk("b_stat_xfers", 32'(b_stat_xfers), 32'(1));
        chk("b_stat_conflicts", 32'(b_stat_conflicts), 32'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
